// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding, default geometry and counter width helper
package demux_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int NCH_DEF = 4;
    localparam int SEL_W_DEF = 2;
    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts 0..DWELL-1 while enabled, wraps itself, flags the last cycle
module dwell_counter
    import demux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int W = clog2(DWELL)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count;
    assign tc = count == W'(DWELL - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: latches a channel pattern and walks sel/d across the demux, DWELL cycles per channel
module demux_dispatcher
    import demux_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH-1:0]   in_pattern,
    input  logic             abort,
    output logic             d,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done
);
    state_t state, state_n;
    logic [NCH-1:0] pat, pat_n;
    logic [SEL_W-1:0] sel_n, sel_inc;
    logic d_n, done_n, accept, step, last, tc;

    assign in_ready = (state == IDLE) & ~abort;

    dwell_counter #(.DWELL(DWELL)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(abort | (state == IDLE)),
        .en(state == RUN),
        .tc(tc)
    );

    always_comb begin
        sel_inc = sel + 1'b1;
        accept = in_valid & in_ready;
        step = (state == RUN) & tc & ~abort;
        last = step & (sel == SEL_W'(NCH - 1));
        state_n = (abort | last) ? IDLE : accept ? RUN : state;
        sel_n = (abort | last | accept) ? '0 : step ? sel_inc : sel;
        d_n = (abort | last) ? 1'b0 : accept ? in_pattern[0] : step ? pat[sel_inc] : d;
        done_n = last;
        pat_n = accept ? in_pattern : pat;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            d <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pat <= '0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            d <= d_n;
            busy <= state_n == RUN;
            done <= done_n;
            pat <= pat_n;
        end
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed checks of the dispatcher with a behavioural 1:4 demux on its outputs
module tb_demux_dispatcher;
    logic clk = 0, rst = 1;
    logic in_valid = 0, abort = 0, in_ready, d, busy, done;
    logic [3:0] in_pattern = '0;
    logic [1:0] sel;
    logic in_valid1 = 0, abort1 = 0, in_ready1, d1, busy1, done1;
    logic [3:0] in_pattern1 = '0;
    logic [1:0] sel1;
    logic [3:0] z;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign z = {3'b000, d} << sel;

    demux_dispatcher #(.NCH(4), .SEL_W(2), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .abort(abort), .d(d), .sel(sel), .busy(busy), .done(done)
    );

    demux_dispatcher #(.NCH(4), .SEL_W(2), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_pattern(in_pattern1), .abort(abort1), .d(d1), .sel(sel1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_check(input logic [3:0] p, input logic hold, input int pulse_at);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                chk("frame_sel", 8'(sel), 8'(i));
                chk("frame_d", 8'(d), 8'(p[i]));
                chk("frame_busy", 8'(busy), 8'd1);
                chk("frame_done", 8'(done), 8'd0);
                chk("frame_z", 8'(z), p[i] ? 8'(4'b0001 << i) : 8'd0);
                in_valid = hold | (i * 4 + j == pulse_at);
                tick();
            end
    endtask

    task automatic done_check(input string tag);
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_sel"}, 8'(sel), 8'd0);
        chk({tag, "_d"}, 8'(d), 8'd0);
        chk({tag, "_ready"}, 8'(in_ready), 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_d", 8'(d), 8'd0);
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd1);
        rst = 0;
        tick();
        // test 1: asynchronous reset in the middle of a frame
        in_valid = 1;
        in_pattern = 4'b1111;
        tick();
        in_valid = 0;
        repeat (3) tick();
        chk("t1_busy_pre", 8'(busy), 8'd1);
        chk("t1_d_pre", 8'(d), 8'd1);
        #2 rst = 1;
        #1;
        chk("t1_d", 8'(d), 8'd0);
        chk("t1_sel", 8'(sel), 8'd0);
        chk("t1_busy", 8'(busy), 8'd0);
        @(negedge clk) rst = 0;
        tick();
        chk("t1_ready", 8'(in_ready), 8'd1);
        chk("t1_done", 8'(done), 8'd0);
        tick();
        chk("t1_done2", 8'(done), 8'd0);
        chk("t1_busy2", 8'(busy), 8'd0);
        // test 2: single frame 1011
        in_valid = 1;
        in_pattern = 4'b1011;
        tick();
        in_valid = 0;
        frame_check(4'b1011, 1'b0, -1);
        done_check("t2");
        tick();
        chk("t2_done_once", 8'(done), 8'd0);
        chk("t2_idle", 8'(busy), 8'd0);
        // test 3: back-to-back frames with in_valid held
        in_valid = 1;
        in_pattern = 4'b1111;
        tick();
        in_pattern = 4'b0101;
        frame_check(4'b1111, 1'b1, -1);
        done_check("t3");
        tick();
        in_valid = 0;
        frame_check(4'b0101, 1'b0, -1);
        done_check("t3b");
        tick();
        // test 4: abort in the second cycle of channel 2
        in_valid = 1;
        in_pattern = 4'b1111;
        tick();
        in_valid = 0;
        repeat (9) tick();
        chk("t4_sel_pre", 8'(sel), 8'd2);
        abort = 1;
        #1;
        chk("t4_ready_abort", 8'(in_ready), 8'd0);
        tick();
        chk("t4_d", 8'(d), 8'd0);
        chk("t4_sel", 8'(sel), 8'd0);
        chk("t4_busy", 8'(busy), 8'd0);
        chk("t4_done", 8'(done), 8'd0);
        in_valid = 1;
        tick();
        chk("t4_no_accept", 8'(busy), 8'd0);
        abort = 0;
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_no_done", 8'(done), 8'd0);
        end
        chk("t4_idle", 8'(busy), 8'd0);
        // test 5: pattern change and in_valid pulse while busy
        in_valid = 1;
        in_pattern = 4'b1011;
        tick();
        in_valid = 0;
        in_pattern = 4'b0000;
        frame_check(4'b1011, 1'b0, 6);
        done_check("t5");
        tick();
        chk("t5_no_extra", 8'(busy), 8'd0);
        chk("t5_sel", 8'(sel), 8'd0);
        // test 6: DWELL=1 instance
        chk("t6_ready", 8'(in_ready1), 8'd1);
        in_valid1 = 1;
        in_pattern1 = 4'b1011;
        tick();
        in_valid1 = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_sel", 8'(sel1), 8'(i));
            chk("t6_d", 8'(d1), 8'(in_pattern1[i]));
            chk("t6_busy", 8'(busy1), 8'd1);
            chk("t6_done_early", 8'(done1), 8'd0);
            tick();
        end
        chk("t6_done", 8'(done1), 8'd1);
        chk("t6_sel_end", 8'(sel1), 8'd0);
        tick();
        chk("t6_done_once", 8'(done1), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
